// File: rtl/maze_pkg.sv
// Shared definitions for the multi-player maze movement engine.
// Contents:
//   BIT_UP/DOWN/LEFT/RIGHT : bit positions inside a 4-bit direction request nibble
//   dir_t                  : decoded single direction handed from the rate block
//   state_t                : game-phase FSM encoding (IDLE=0, PLAY=1, WON=2)
//   cell_index()           : flat bitmap index of cell (x,y), row-major y*width+x
package maze_pkg;

    localparam int BIT_RIGHT = 0;
    localparam int BIT_LEFT  = 1;
    localparam int BIT_DOWN  = 2;
    localparam int BIT_UP    = 3;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2
    } state_t;

    function automatic int cell_index(input int x, input int y, input int width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/maze_move_rate.sv
// Per-player auto-repeat rate limiter and direction priority decoder.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : restart pulse (load), zeroes the repeat counter
//   run        : movement allowed this cycle (PLAY and enable); counter holds when low
//   req[3:0]   : {up,down,left,right} level request
//   attempt    : one-cycle strobe, a move should be tried this cycle
//   dir[1:0]   : decoded direction (dir_t encoding), valid with attempt
module maze_move_rate
    import maze_pkg::*;
#(
    parameter int MOVE_DIV = 20_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       run,
    input  logic [3:0] req,
    output logic       attempt,
    output logic [1:0] dir
);

    localparam int CNT_W = $clog2(MOVE_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MOVE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Priority decode of the request nibble: up beats down beats left beats right.
    // Right is the fall-through so an all-zero nibble still yields a defined code;
    // attempt is never raised for a zero nibble, so the code is ignored then.
    always_comb begin
        dir = DIR_RIGHT;
        if (req[BIT_UP])
            dir = DIR_UP;
        else if (req[BIT_DOWN])
            dir = DIR_DOWN;
        else if (req[BIT_LEFT])
            dir = DIR_LEFT;
    end

    // A zero counter with a held request means "move now"; this makes the very
    // first press act immediately and later ones every MOVE_DIV cycles.
    assign attempt = run && (req != 4'b0000) && (cnt == '0);

    // Repeat counter: cleared on release or restart, reloaded on every attempt
    // (successful or blocked), otherwise counting down. Frozen while not running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            if (req == 4'b0000)
                cnt <= '0;
            else if (cnt == '0)
                cnt <= RELOAD;
            else
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/maze_multi_move.sv
// Multi-player maze movement engine with first-to-finish detection.
// Optional feature macro: MAZE_MOVE_COLLIDE_EN (players block each other).
// Ports:
//   clk, reset               : system clock, asynchronous active-high reset
//   enable                   : movement allowed (top-level move state)
//   load                     : pulse, place every player at start and enter PLAY
//   start_x/y, finish_x/y    : start and finish cells
//   maze_width/height        : runtime bounds of the playable area
//   maze_data                : open-cell bitmap, bit y*MAZE_W+x
//   dir_req                  : per-player {up,down,left,right} nibbles
//   pos_x/pos_y              : packed per-player coordinates
//   moved                    : per-player one-cycle pulse on a successful move
//   winner_valid/winner_id   : latched first player to reach finish
//   state                    : game phase (0=IDLE, 1=PLAY, 2=WON)
module maze_multi_move
    import maze_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 4,
    parameter int MAZE_W      = 16,
    parameter int MAZE_H      = 16,
    parameter int MOVE_DIV    = 20_000_000,
    parameter int PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           load,
    input  logic [COORD_W-1:0]             start_x,
    input  logic [COORD_W-1:0]             start_y,
    input  logic [COORD_W-1:0]             finish_x,
    input  logic [COORD_W-1:0]             finish_y,
    input  logic [COORD_W:0]               maze_width,
    input  logic [COORD_W:0]               maze_height,
    input  logic [MAZE_W*MAZE_H-1:0]       maze_data,
    input  logic [4*NUM_PLAYERS-1:0]       dir_req,
    output logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
    output logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
    output logic [NUM_PLAYERS-1:0]         moved,
    output logic                           winner_valid,
    output logic [PID_W-1:0]               winner_id,
    output logic [1:0]                     state
);

    localparam int IDX_W = $clog2(MAZE_W * MAZE_H);
    localparam logic [COORD_W:0] ONE   = (COORD_W+1)'(1);
    localparam logic [COORD_W:0] LIM_W = (COORD_W+1)'(MAZE_W);
    localparam logic [COORD_W:0] LIM_H = (COORD_W+1)'(MAZE_H);

    state_t state_q, state_d;

    logic [COORD_W-1:0] px [NUM_PLAYERS];
    logic [COORD_W-1:0] py [NUM_PLAYERS];
    logic [COORD_W-1:0] nx [NUM_PLAYERS];
    logic [COORD_W-1:0] ny [NUM_PLAYERS];
    logic [1:0]         dir [NUM_PLAYERS];

    logic [NUM_PLAYERS-1:0] attempt;
    logic [NUM_PLAYERS-1:0] mv;
    logic [COORD_W:0]       tx, ty;
    logic                   ok;
    logic                   run;
    logic                   win_hit;
    logic [PID_W-1:0]       win_idx;

    assign run = (state_q == ST_PLAY) && enable;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        maze_move_rate #(
            .MOVE_DIV (MOVE_DIV)
        ) u_rate (
            .clk     (clk),
            .reset   (reset),
            .clear   (load),
            .run     (run),
            .req     (dir_req[4*g +: 4]),
            .attempt (attempt[g]),
            .dir     (dir[g])
        );

        assign pos_x[COORD_W*g +: COORD_W] = px[g];
        assign pos_y[COORD_W*g +: COORD_W] = py[g];
    end

    // Next-position evaluation. Targets are formed one bit wider than a
    // coordinate so stepping right/down past the top of the range cannot wrap;
    // stepping up/left from 0 is rejected explicitly. Players are visited in
    // index order so, with collisions enabled, a lower-index player's freshly
    // claimed cell is already visible to the higher-index players.
    always_comb begin
        mv = '0;
        tx = '0;
        ty = '0;
        ok = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            nx[p] = px[p];
            ny[p] = py[p];
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            tx = {1'b0, px[p]};
            ty = {1'b0, py[p]};
            ok = attempt[p];
            case (dir[p])
                DIR_UP: begin
                    if (py[p] == '0) ok = 1'b0;
                    else             ty = ty - ONE;
                end
                DIR_DOWN:  ty = ty + ONE;
                DIR_LEFT: begin
                    if (px[p] == '0) ok = 1'b0;
                    else             tx = tx - ONE;
                end
                default:   tx = tx + ONE;
            endcase
            if (tx >= maze_width || ty >= maze_height || tx >= LIM_W || ty >= LIM_H)
                ok = 1'b0;
            else if (!maze_data[IDX_W'(cell_index(int'(tx), int'(ty), MAZE_W))])
                ok = 1'b0;
`ifdef MAZE_MOVE_COLLIDE_EN
            for (int q = 0; q < NUM_PLAYERS; q++) begin
                if (q != p && tx == {1'b0, px[q]} && ty == {1'b0, py[q]})
                    ok = 1'b0;
                if (q < p && tx == {1'b0, nx[q]} && ty == {1'b0, ny[q]})
                    ok = 1'b0;
            end
`endif
            if (ok) begin
                nx[p] = tx[COORD_W-1:0];
                ny[p] = ty[COORD_W-1:0];
                mv[p] = 1'b1;
            end
        end
    end

    // Finish detection on the positions about to be registered; the first
    // (lowest-index) player found on the finish cell is the winner.
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (!win_hit && nx[p] == finish_x && ny[p] == finish_y) begin
                win_hit = 1'b1;
                win_idx = PID_W'(p);
            end
        end
    end

    // Game-phase next state. load restarts from any phase and outranks a win
    // happening on the same edge.
    always_comb begin
        state_d = state_q;
        if (load)
            state_d = ST_PLAY;
        else if (state_q == ST_PLAY && win_hit)
            state_d = ST_WON;
    end

    // Game-phase state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Positions, move pulses and the latched winner. Positions only advance
    // while running, so with enable low or outside PLAY everything holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                px[p] <= '0;
                py[p] <= '0;
            end
            moved        <= '0;
            winner_valid <= 1'b0;
            winner_id    <= '0;
        end else if (load) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                px[p] <= start_x;
                py[p] <= start_y;
            end
            moved        <= '0;
            winner_valid <= 1'b0;
            winner_id    <= '0;
        end else begin
            moved <= run ? mv : '0;
            if (run) begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    px[p] <= nx[p];
                    py[p] <= ny[p];
                end
            end
            if (state_q == ST_PLAY && win_hit) begin
                winner_valid <= 1'b1;
                winner_id    <= win_idx;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_maze_multi_move.sv
// Self-checking bench for maze_multi_move: directed scenarios followed by a
// randomized run, every cycle compared against a cell-level game model.
module tb_maze_multi_move;

    localparam int NP = 2;
    localparam int CW = 4;
    localparam int MW = 16;
    localparam int MH = 16;
    localparam int MD = 4;
    localparam int PW = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              load;
    logic [CW-1:0]     start_x, start_y, finish_x, finish_y;
    logic [CW:0]       maze_width, maze_height;
    logic [MW*MH-1:0]  maze_data;
    logic [4*NP-1:0]   dir_req;
    logic [NP*CW-1:0]  pos_x, pos_y;
    logic [NP-1:0]     moved;
    logic              winner_valid;
    logic [PW-1:0]     winner_id;
    logic [1:0]        state;

    int checkCount = 0;
    int passCount  = 0;

    // Reference game state: plain integer cell coordinates and cycle counters.
    int mx [NP];
    int my [NP];
    int mcnt [NP];
    int mmoved [NP];
    int mstate, mwv, mwid;

    maze_multi_move #(
        .NUM_PLAYERS (NP),
        .COORD_W     (CW),
        .MAZE_W      (MW),
        .MAZE_H      (MH),
        .MOVE_DIV    (MD),
        .PID_W       (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .start_x      (start_x),
        .start_y      (start_y),
        .finish_x     (finish_x),
        .finish_y     (finish_y),
        .maze_width   (maze_width),
        .maze_height  (maze_height),
        .maze_data    (maze_data),
        .dir_req      (dir_req),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .moved        (moved),
        .winner_valid (winner_valid),
        .winner_id    (winner_id),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    function automatic bit cellOpen(input int x, input int y);
        if (x < 0 || y < 0 || x >= int'(maze_width) || y >= int'(maze_height))
            return 1'b0;
        return maze_data[y*MW + x];
    endfunction

    task automatic modelReset();
        for (int p = 0; p < NP; p++) begin
            mx[p] = 0; my[p] = 0; mcnt[p] = 0; mmoved[p] = 0;
        end
        mstate = 0; mwv = 0; mwid = 0;
    endtask

    // One clock edge of the game as described by its rules.
    task automatic modelStep();
        int ox [NP];
        int oy [NP];
        int nib, dx, dy, tx, ty;
        bit ok, found;
        if (load) begin
            for (int p = 0; p < NP; p++) begin
                mx[p] = int'(start_x); my[p] = int'(start_y);
                mcnt[p] = 0; mmoved[p] = 0;
            end
            mstate = 1; mwv = 0; mwid = 0;
            return;
        end
        for (int p = 0; p < NP; p++) begin
            mmoved[p] = 0;
            ox[p] = mx[p];
            oy[p] = my[p];
        end
        if (mstate == 1 && enable) begin
            for (int p = 0; p < NP; p++) begin
                nib = int'((dir_req >> (4*p)) & 8'h0F);
                if (nib == 0) begin
                    mcnt[p] = 0;
                end else if (mcnt[p] == 0) begin
                    mcnt[p] = MD - 1;
                    dx = 0; dy = 0;
                    if ((nib & 8) != 0)      dy = -1;
                    else if ((nib & 4) != 0) dy = 1;
                    else if ((nib & 2) != 0) dx = -1;
                    else                     dx = 1;
                    tx = mx[p] + dx;
                    ty = my[p] + dy;
                    ok = cellOpen(tx, ty);
`ifdef MAZE_MOVE_COLLIDE_EN
                    for (int q = 0; q < NP; q++) begin
                        if (q != p && tx == ox[q] && ty == oy[q]) ok = 1'b0;
                        if (q < p && tx == mx[q] && ty == my[q]) ok = 1'b0;
                    end
`endif
                    if (ok) begin
                        mx[p] = tx; my[p] = ty; mmoved[p] = 1;
                    end
                end else begin
                    mcnt[p] = mcnt[p] - 1;
                end
            end
        end
        if (mstate == 1) begin
            found = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (!found && mx[p] == int'(finish_x) && my[p] == int'(finish_y)) begin
                    found = 1'b1;
                    mstate = 2; mwv = 1; mwid = p;
                end
            end
        end
    endtask

    task automatic checkAll(input string ctx);
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("%s pos_x[%0d]", ctx, p), int'(pos_x[CW*p +: CW]), mx[p]);
            checkOutput($sformatf("%s pos_y[%0d]", ctx, p), int'(pos_y[CW*p +: CW]), my[p]);
            checkOutput($sformatf("%s moved[%0d]", ctx, p), int'(moved[p]), mmoved[p]);
        end
        checkOutput($sformatf("%s state", ctx), int'(state), mstate);
        checkOutput($sformatf("%s winner_valid", ctx), int'(winner_valid), mwv);
        checkOutput($sformatf("%s winner_id", ctx), int'(winner_id), mwid);
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model on the
    // rising edge, and compare at the next falling edge.
    task automatic applyStimulus(input logic ld, input logic en, input logic [4*NP-1:0] dr,
                                 input string ctx);
        load    = ld;
        enable  = en;
        dir_req = dr;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkAll(ctx);
    endtask

    task automatic doReset();
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkAll("reset");
        reset = 1'b0;
    endtask

    int movedCount;
    logic [4*NP-1:0] rdir;

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        load = 1'b0;
        dir_req = '0;
        start_x = '0; start_y = '0;
        finish_x = 4'd3; finish_y = 4'd3;
        maze_width = 5'd4; maze_height = 5'd4;
        maze_data = '1;
        doReset();

        // Free run along the top row of a 4x4 open maze
        applyStimulus(1'b1, 1'b1, 8'h00, "t1 load");
        movedCount = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h01, "t1 hold");
            movedCount += int'(moved[0]);
            if (i == 0) checkOutput("t1 x at cycle1", int'(pos_x[3:0]), 1);
            if (i == 4) checkOutput("t1 x at cycle5", int'(pos_x[3:0]), 2);
            if (i == 8) checkOutput("t1 x at cycle9", int'(pos_x[3:0]), 3);
        end
        checkOutput("t1 moved pulses", movedCount, 3);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h01, "t1 edge");
        checkOutput("t1 x at boundary", int'(pos_x[3:0]), 3);

        // Wall at (1,0): blocked attempt still reloads the counter
        maze_data[1] = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h00, "t2 load");
        applyStimulus(1'b0, 1'b1, 8'h01, "t2 wall");
        checkOutput("t2 blocked x", int'(pos_x[3:0]), 0);
        checkOutput("t2 blocked moved", int'(moved[0]), 0);
        maze_data[1] = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h01, "t2 wait");
        checkOutput("t2 x before retry", int'(pos_x[3:0]), 0);
        applyStimulus(1'b0, 1'b1, 8'h01, "t2 retry");
        checkOutput("t2 x after retry", int'(pos_x[3:0]), 1);

        // Simultaneous arrival at finish (1,0): lowest index wins
        finish_x = 4'd1; finish_y = 4'd0;
        applyStimulus(1'b1, 1'b1, 8'h00, "t3 load");
        applyStimulus(1'b0, 1'b1, 8'h11, "t3 race");
        checkOutput("t3 state won", int'(state), 2);
        checkOutput("t3 winner_id", int'(winner_id), 0);
        checkOutput("t3 winner_valid", int'(winner_valid), 1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 8'h44, "t3 frozen");
        checkOutput("t3 still won", int'(state), 2);
        checkOutput("t3 p0 y frozen", int'(pos_y[3:0]), 0);

        // Priority: up beats left, and up from row 0 is blocked
        finish_x = 4'd3; finish_y = 4'd3;
        applyStimulus(1'b1, 1'b1, 8'h00, "t4 load");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hA0, "t4 upleft");
        checkOutput("t4 p1 x held", int'(pos_x[7:4]), 0);
        checkOutput("t4 p1 y held", int'(pos_y[7:4]), 0);
        applyStimulus(1'b0, 1'b1, 8'h00, "t4 release");
        applyStimulus(1'b0, 1'b1, 8'h10, "t4 right");
        checkOutput("t4 p1 immediate move", int'(pos_x[7:4]), 1);

        // enable low freezes the repeat count mid-hold
        applyStimulus(1'b1, 1'b1, 8'h00, "t5 load");
        applyStimulus(1'b0, 1'b1, 8'h01, "t5 hold");
        applyStimulus(1'b0, 1'b1, 8'h01, "t5 hold");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'h01, "t5 disabled");
        checkOutput("t5 x frozen", int'(pos_x[3:0]), 1);
        applyStimulus(1'b0, 1'b1, 8'h01, "t5 resume");
        applyStimulus(1'b0, 1'b1, 8'h01, "t5 resume");
        checkOutput("t5 x before resumed move", int'(pos_x[3:0]), 1);
        applyStimulus(1'b0, 1'b1, 8'h01, "t5 resume");
        checkOutput("t5 x after resumed move", int'(pos_x[3:0]), 2);

        // Asynchronous reset between clock edges
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5 async pos_x", int'(pos_x), 0);
        checkOutput("t5 async state", int'(state), 0);
        checkOutput("t5 async winner", int'(winner_valid), 0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h11, "t5 idle after reset");

        // Overlap / collision between players
        applyStimulus(1'b1, 1'b1, 8'h00, "t6 load");
        applyStimulus(1'b0, 1'b1, 8'h01, "t6 p0 step");
        applyStimulus(1'b0, 1'b1, 8'h10, "t6 p1 step");
`ifdef MAZE_MOVE_COLLIDE_EN
        checkOutput("t6 p1 blocked by p0", int'(pos_x[7:4]), 0);
`else
        checkOutput("t6 p1 overlaps p0", int'(pos_x[7:4]), 1);
`endif

        // Randomized play on random mazes
        rdir = '0;
        for (int i = 0; i < 2000; i++) begin
            logic ld;
            ld = (i == 0) || ($urandom_range(0, 99) < 3);
            if (ld) begin
                for (int c = 0; c < MW*MH; c++) maze_data[c] = ($urandom_range(0, 3) != 0);
                maze_width  = 5'($urandom_range(1, 16));
                maze_height = 5'($urandom_range(1, 16));
                start_x  = 4'($urandom_range(0, int'(maze_width) - 1));
                start_y  = 4'($urandom_range(0, int'(maze_height) - 1));
                finish_x = 4'($urandom_range(0, int'(maze_width) - 1));
                finish_y = 4'($urandom_range(0, int'(maze_height) - 1));
            end
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 9) < 3) rdir[4*p +: 4] = 4'($urandom_range(0, 15));
            applyStimulus(ld, ($urandom_range(0, 9) != 0), rdir, "rand");
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
